mdl_supbd_crc: RTL



---
 rtl/supbd_pkg.sv | 17 +
 rtl/crc16_step.sv | 19 +
 rtl/mdl_supbd_crc.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/supbd_pkg.sv
// Shared definitions for the SUPBD CRC sequencer: state encoding, field length and CRC defaults.
package supbd_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAccum,
        StSupbd,
        StEnd,
        StWait
    } supbd_state_e;

    localparam int unsigned SUPBD_BITS = 16;

    localparam logic [15:0] CRC_POLY_DEFAULT = 16'h1021;
    localparam logic [15:0] CRC_INIT_DEFAULT = 16'h0000;

endpackage

// File: rtl/crc16_step.sv
// One-bit MSB-first CRC-16 update; chained twice for two bits per tick.
module crc16_step
    import supbd_pkg::*;
#(
    parameter logic [15:0] POLY = CRC_POLY_DEFAULT
) (
    input  logic [15:0] crc_i,
    input  logic        bit_i,
    output logic [15:0] crc_o
);

    logic feedback;

    always_comb begin
        feedback = crc_i[15] ^ bit_i;
        crc_o    = {crc_i[14:0], 1'b0} ^ (feedback ? POLY : 16'h0000);
    end

endmodule

// File: rtl/mdl_supbd_crc.sv
// Supplementary bubble data sequencer: accumulates CRC-16 over effective data, then emits (write)
// or checks (read) the 16 CRC bits across the SUPBD start/end handshake.
module mdl_supbd_crc
    import supbd_pkg::*;
#(
    parameter logic [15:0] CRC_POLY = CRC_POLY_DEFAULT,
    parameter logic [15:0] CRC_INIT = CRC_INIT_DEFAULT
) (
    input  logic       i_MCLK,
    input  logic       i_RST,
    input  logic       i_CLK2M_PCEN_n,
    input  logic       i_4BEN_n,
    input  logic       i_WRMODE,
    input  logic       i_PG_START,
    input  logic       i_EFFBD_VLD,
    input  logic [1:0] i_EFFBD_D,
    input  logic [1:0] i_SUPBD_D,
    input  logic       i_SUPBD_START_n,
    output logic       o_SUPBD_END_n,
    output logic [1:0] o_SUPBD_D,
    output logic       o_SUPBD_VLD,
    output logic       o_CRC_ERR,
    output logic       o_BUSY
);

    localparam logic [4:0] CntLast = 5'(SUPBD_BITS);

    supbd_state_e state_q, state_d;
    logic [15:0]  crc_q, crc_d;
    logic [4:0]   cnt_q, cnt_d;
    logic         mode4_q, mode4_d;
    logic         wr_q, wr_d;
    logic         err_q, err_d;

    logic         tick;
    logic         step1_bit;
    logic [15:0]  step1_crc, step2_crc;
    logic [4:0]   cnt_nxt;
    logic         cnt_done;
    logic         rx_mismatch;

    assign tick = ~i_CLK2M_PCEN_n;

    // 4-bit mode feeds bit[1] then bit[0]; 2-bit mode feeds only bit[0] through the first stage
    assign step1_bit = i_4BEN_n ? i_EFFBD_D[0] : i_EFFBD_D[1];

    crc16_step #(
        .POLY (CRC_POLY)
    ) u_step1 (
        .crc_i (crc_q),
        .bit_i (step1_bit),
        .crc_o (step1_crc)
    );

    crc16_step #(
        .POLY (CRC_POLY)
    ) u_step2 (
        .crc_i (step1_crc),
        .bit_i (i_EFFBD_D[0]),
        .crc_o (step2_crc)
    );

    assign cnt_nxt     = cnt_q + (mode4_q ? 5'd2 : 5'd1);
    assign cnt_done    = (cnt_nxt == CntLast);
    assign rx_mismatch = mode4_q ? (i_SUPBD_D != crc_q[15:14]) : (i_SUPBD_D[0] != crc_q[15]);

    always_ff @(posedge i_MCLK) begin
        if (i_RST) begin
            state_q <= StIdle;
        end else if (tick) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StAccum: begin
                if (i_PG_START) begin
                    state_d = StAccum;
                end else if (!i_SUPBD_START_n) begin
                    state_d = StSupbd;
                end
            end
            StSupbd: if (cnt_done) state_d = StEnd;
            StEnd:   state_d = StWait;
            StWait:  if (i_SUPBD_START_n) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next state; data on the tick a field starts is not accumulated
    always_comb begin
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        mode4_d = mode4_q;
        wr_d    = wr_q;
        err_d   = err_q;
        case (state_q)
            StIdle, StAccum: begin
                if (i_PG_START) begin
                    crc_d = CRC_INIT;
                    err_d = 1'b0;
                end else if (!i_SUPBD_START_n) begin
                    cnt_d   = '0;
                    mode4_d = ~i_4BEN_n;
                    wr_d    = i_WRMODE;
                    err_d   = 1'b0;
                end else if (i_EFFBD_VLD) begin
                    crc_d = i_4BEN_n ? step1_crc : step2_crc;
                end
            end
            StSupbd: begin
                cnt_d = cnt_nxt;
                crc_d = mode4_q ? {crc_q[13:0], 2'b00} : {crc_q[14:0], 1'b0};
                if (!wr_q && rx_mismatch) begin
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_MCLK) begin
        if (i_RST) begin
            crc_q   <= CRC_INIT;
            cnt_q   <= '0;
            mode4_q <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else if (tick) begin
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            mode4_q <= mode4_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        o_BUSY        = (state_q == StSupbd);
        o_SUPBD_VLD   = o_BUSY & wr_q;
        o_SUPBD_D     = 2'b00;
        if (o_SUPBD_VLD) begin
            o_SUPBD_D = mode4_q ? crc_q[15:14] : {1'b0, crc_q[15]};
        end
        o_SUPBD_END_n = (state_q != StEnd);
        o_CRC_ERR     = err_q;
    end

endmodule
